// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: RAM handshake, machine word, and memory arbiter
// FSM/grant types visible to the datapath debug logic and testbenches.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IFETCH  = 3'd1,
        DACCESS = 3'd2,
        HALTED  = 3'd3,
        FAULT   = 3'd4
    } arbState_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the memory arbiter's signals; modport ma faces the arbiter,
// modport tb faces whatever drives the datapath and RAM sides.
interface memory_arbiter_if (
    input logic CLK
);
    import cpu_types_pkg::*;

    logic      RST;
    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      halt;
    logic      ihit;
    logic      dhit;
    word_t     iload;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      halted;
    logic      fault;

    modport ma (
        input  CLK, RST, iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
        output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, halted, fault
    );

    modport tb (
        input  CLK, ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, halted, fault,
        output RST, iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate
    );

endinterface

// File: rtl/memory_arbiter.sv
// Shares one RAM port between instruction fetch and data access, alternating
// under contention, retrying RAM errors up to MAX_RETRY and parking on halt.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_RETRY = 3
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    input  logic      halt,
    output logic      ihit,
    output logic      dhit,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      halted,
    output logic      fault
);

    localparam int CNT_W = $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] LAST_TRY = CNT_W'(MAX_RETRY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    arbState_t        state;
    arbState_t        next_state;
    grant_t           last_grant;
    logic [CNT_W-1:0] retry_cnt;
    logic             is_write;
    logic             data_req;
    logic             grant_i;
    logic             grant_d;
    logic             retry_err;

    assign data_req = dREN | dWEN;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        retry_err  = 1'b0;
        unique case (state)
            IDLE: begin
                if (halt && !data_req) begin
                    next_state = HALTED;
                end else if (data_req && (last_grant == GRANT_I || !iREN)) begin
                    next_state = DACCESS;
                    grant_d    = 1'b1;
                end else if (iREN) begin
                    next_state = IFETCH;
                    grant_i    = 1'b1;
                end
            end
            IFETCH, DACCESS: begin
                if (ramstate == ACCESS) begin
                    next_state = IDLE;
                end else if (ramstate == ERROR) begin
                    if (retry_cnt == LAST_TRY) next_state = FAULT;
                    else                       retry_err  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant <= GRANT_I;
            retry_cnt  <= '0;
            ramaddr    <= '0;
            ramstore   <= '0;
            is_write   <= 1'b0;
        end else begin
            if (grant_i) begin
                ramaddr    <= iaddr;
                is_write   <= 1'b0;
                retry_cnt  <= '0;
                last_grant <= GRANT_I;
            end else if (grant_d) begin
                ramaddr    <= daddr;
                ramstore   <= dstore;
                is_write   <= dWEN;
                retry_cnt  <= '0;
                last_grant <= GRANT_D;
            end else if (retry_err && retry_cnt != CNT_MAX) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
        end
    end

    assign ramREN = (state == IFETCH) || (state == DACCESS && !is_write);
    assign ramWEN = (state == DACCESS) && is_write;

    // A transaction abandoned by reset must not report completion.
    assign ihit  = (state == IFETCH)  && (ramstate == ACCESS) && !RST;
    assign dhit  = (state == DACCESS) && (ramstate == ACCESS) && !RST;
    assign iload = ihit ? ramload : '0;
    assign dload = dhit ? ramload : '0;

    assign halted = (state == HALTED);
    assign fault  = (state == FAULT);

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, hand-written
// contention/reset sequences, and randomized traffic against a transaction model.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int MAX_RETRY = 3;
    localparam word_t LOADVAL = 32'h2402_0005;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    memory_arbiter_if bus (.CLK(clk));

    memory_arbiter #(.MAX_RETRY(MAX_RETRY)) dut (
        .CLK     (clk),
        .RST     (bus.RST),
        .iREN    (bus.iREN),
        .iaddr   (bus.iaddr),
        .dREN    (bus.dREN),
        .dWEN    (bus.dWEN),
        .daddr   (bus.daddr),
        .dstore  (bus.dstore),
        .halt    (bus.halt),
        .ihit    (bus.ihit),
        .dhit    (bus.dhit),
        .iload   (bus.iload),
        .dload   (bus.dload),
        .ramREN  (bus.ramREN),
        .ramWEN  (bus.ramWEN),
        .ramaddr (bus.ramaddr),
        .ramstore(bus.ramstore),
        .ramload (bus.ramload),
        .ramstate(bus.ramstate),
        .halted  (bus.halted),
        .fault   (bus.fault)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic apply(input logic rst, input logic i, input logic d, input logic w,
                         input logic h, input ramstate_t rs);
        bus.RST      = rst;
        bus.iREN     = i;
        bus.dREN     = d;
        bus.dWEN     = w;
        bus.halt     = h;
        bus.ramstate = rs;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FREE);
        next_cycle();
        next_cycle();
    endtask

    // Directed vectors: one row per cycle, outputs sampled on the falling edge.
    typedef struct {
        logic      rst, iren, dren, dwen, halt;
        ramstate_t rs;
        logic      e_ren, e_wen, e_ihit, e_dhit, e_halted, e_fault;
        word_t     e_addr;
    } vec_t;

    function automatic vec_t v(input logic rst, input logic i, input logic d, input logic w,
                               input logic h, input ramstate_t rs, input logic ren,
                               input logic wen, input logic ih, input logic dh,
                               input logic hl, input logic ft, input word_t addr);
        vec_t r;
        r.rst = rst; r.iren = i; r.dren = d; r.dwen = w; r.halt = h; r.rs = rs;
        r.e_ren = ren; r.e_wen = wen; r.e_ihit = ih; r.e_dhit = dh;
        r.e_halted = hl; r.e_fault = ft; r.e_addr = addr;
        return r;
    endfunction

    // Transaction-level reference model state.
    logic  m_serv_i, m_serv_d, m_write, m_parked, m_dead, m_last_d;
    int    m_errs;
    word_t m_addr, m_store;

    task automatic model_reset();
        m_serv_i = 0; m_serv_d = 0; m_write = 0; m_parked = 0; m_dead = 0;
        m_last_d = 0; m_errs = 0; m_addr = '0; m_store = '0;
    endtask

    task automatic model_step();
        logic dreq;
        dreq = bus.dREN | bus.dWEN;
        if (bus.RST) begin
            model_reset();
        end else if (m_serv_i || m_serv_d) begin
            if (bus.ramstate == ACCESS) begin
                m_serv_i = 0; m_serv_d = 0;
            end else if (bus.ramstate == ERROR) begin
                m_errs++;
                if (m_errs == MAX_RETRY) begin
                    m_serv_i = 0; m_serv_d = 0; m_dead = 1;
                end
            end
        end else if (!m_parked && !m_dead) begin
            if (bus.halt && !dreq) begin
                m_parked = 1;
            end else if (dreq && (!m_last_d || !bus.iREN)) begin
                m_serv_d = 1; m_write = bus.dWEN; m_addr = bus.daddr;
                m_store = bus.dstore; m_errs = 0; m_last_d = 1;
            end else if (bus.iREN) begin
                m_serv_i = 1; m_addr = bus.iaddr; m_errs = 0; m_last_d = 0;
            end
        end
    endtask

    initial begin
        vec_t vecs[$];
        logic  exp_ih, exp_dh, req_i, req_d;
        int    r;

        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0; bus.ramload = '0;
        do_reset();

        // ---------------- directed table ----------------
        bus.iaddr   = 32'h0000_0040;
        bus.daddr   = 32'h0000_0200;
        bus.dstore  = 32'hDEAD_BEEF;
        bus.ramload = LOADVAL;
        //              rst i d w h  rs      ren wen ih dh hl ft addr
        vecs.push_back(v(1, 0,0,0,0, FREE,   0,  0,  0, 0, 0, 0, 32'h0));
        vecs.push_back(v(0, 1,0,0,0, FREE,   0,  0,  0, 0, 0, 0, 32'h0));
        vecs.push_back(v(0, 1,0,0,0, ACCESS, 1,  0,  1, 0, 0, 0, 32'h40));
        vecs.push_back(v(0, 0,0,1,0, FREE,   0,  0,  0, 0, 0, 0, 32'h40));
        vecs.push_back(v(0, 0,0,1,0, BUSY,   0,  1,  0, 0, 0, 0, 32'h200));
        vecs.push_back(v(0, 0,0,1,0, BUSY,   0,  1,  0, 0, 0, 0, 32'h200));
        vecs.push_back(v(0, 0,0,1,0, BUSY,   0,  1,  0, 0, 0, 0, 32'h200));
        vecs.push_back(v(0, 0,0,1,0, ACCESS, 0,  1,  0, 1, 0, 0, 32'h200));
        vecs.push_back(v(0, 0,1,0,0, FREE,   0,  0,  0, 0, 0, 0, 32'h200));
        vecs.push_back(v(0, 0,1,0,0, ERROR,  1,  0,  0, 0, 0, 0, 32'h200));
        vecs.push_back(v(0, 0,1,0,0, ERROR,  1,  0,  0, 0, 0, 0, 32'h200));
        vecs.push_back(v(0, 0,1,0,0, ACCESS, 1,  0,  0, 1, 0, 0, 32'h200));
        vecs.push_back(v(0, 0,1,0,0, FREE,   0,  0,  0, 0, 0, 0, 32'h200));
        vecs.push_back(v(0, 0,1,0,0, ERROR,  1,  0,  0, 0, 0, 0, 32'h200));
        vecs.push_back(v(0, 0,1,0,0, ERROR,  1,  0,  0, 0, 0, 0, 32'h200));
        vecs.push_back(v(0, 0,1,0,0, ERROR,  1,  0,  0, 0, 0, 0, 32'h200));
        vecs.push_back(v(0, 1,1,0,0, ACCESS, 0,  0,  0, 0, 0, 1, 32'h200));
        vecs.push_back(v(0, 1,1,0,0, ACCESS, 0,  0,  0, 0, 0, 1, 32'h200));
        vecs.push_back(v(1, 0,0,0,0, FREE,   0,  0,  0, 0, 0, 1, 32'h200));
        vecs.push_back(v(0, 0,0,1,1, FREE,   0,  0,  0, 0, 0, 0, 32'h0));
        vecs.push_back(v(0, 0,0,1,1, ACCESS, 0,  1,  0, 1, 0, 0, 32'h200));
        vecs.push_back(v(0, 1,0,0,1, FREE,   0,  0,  0, 0, 0, 0, 32'h200));
        vecs.push_back(v(0, 1,0,0,0, ACCESS, 0,  0,  0, 0, 1, 0, 32'h200));
        vecs.push_back(v(0, 1,0,0,0, ACCESS, 0,  0,  0, 0, 1, 0, 32'h200));
        vecs.push_back(v(1, 0,0,0,0, FREE,   0,  0,  0, 0, 1, 0, 32'h200));
        vecs.push_back(v(0, 0,0,0,0, FREE,   0,  0,  0, 0, 0, 0, 32'h0));

        for (int k = 0; k < vecs.size(); k++) begin
            apply(vecs[k].rst, vecs[k].iren, vecs[k].dren, vecs[k].dwen, vecs[k].halt, vecs[k].rs);
            @(negedge clk);
            check($sformatf("vec%0d ramREN", k),  32'(bus.ramREN),  32'(vecs[k].e_ren));
            check($sformatf("vec%0d ramWEN", k),  32'(bus.ramWEN),  32'(vecs[k].e_wen));
            check($sformatf("vec%0d ihit", k),    32'(bus.ihit),    32'(vecs[k].e_ihit));
            check($sformatf("vec%0d dhit", k),    32'(bus.dhit),    32'(vecs[k].e_dhit));
            check($sformatf("vec%0d halted", k),  32'(bus.halted),  32'(vecs[k].e_halted));
            check($sformatf("vec%0d fault", k),   32'(bus.fault),   32'(vecs[k].e_fault));
            check($sformatf("vec%0d ramaddr", k), bus.ramaddr,      vecs[k].e_addr);
            check($sformatf("vec%0d iload", k),   bus.iload,  vecs[k].e_ihit ? LOADVAL : 32'h0);
            check($sformatf("vec%0d dload", k),   bus.dload,  vecs[k].e_dhit ? LOADVAL : 32'h0);
            if (vecs[k].e_wen)
                check($sformatf("vec%0d ramstore", k), bus.ramstore, 32'hDEAD_BEEF);
            next_cycle();
        end

        // ---------------- contention: D, I, D, I while both held ----------------
        do_reset();
        bus.iaddr = 32'h0000_0080;
        bus.daddr = 32'h0000_0100;
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ACCESS);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("cont%0d dhit", c), 32'(bus.dhit), 32'(c % 4 == 1));
            check($sformatf("cont%0d ihit", c), 32'(bus.ihit), 32'(c % 4 == 3));
            if (c % 2 == 1)
                check($sformatf("cont%0d ramaddr", c), bus.ramaddr,
                      (c % 4 == 1) ? 32'h100 : 32'h80);
            next_cycle();
        end

        // ---------------- reset during a stalled data read ----------------
        do_reset();
        bus.daddr = 32'h0000_0300;
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BUSY);
        @(negedge clk);
        check("rstmid idle ramREN", 32'(bus.ramREN), 32'h0);
        next_cycle();
        @(negedge clk);
        check("rstmid busy ramREN", 32'(bus.ramREN), 32'h1);
        check("rstmid busy ramaddr", bus.ramaddr, 32'h300);
        next_cycle();
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ACCESS);
        @(negedge clk);
        check("rstmid no dhit", 32'(bus.dhit), 32'h0);
        check("rstmid no dload", bus.dload, 32'h0);
        next_cycle();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ACCESS);
        @(negedge clk);
        check("rstmid after ramREN", 32'(bus.ramREN), 32'h0);
        check("rstmid after ramaddr", bus.ramaddr, 32'h0);
        check("rstmid after ramstore", bus.ramstore, 32'h0);
        check("rstmid after dhit", 32'(bus.dhit), 32'h0);
        next_cycle();

        // ---------------- randomized traffic vs. model ----------------
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            model_reset();
            req_i = 0; req_d = 0;
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FREE);
            for (int c = 0; c < 300; c++) begin
                if (!req_i && $urandom_range(1, 0) == 1) begin
                    req_i = 1; bus.iaddr = $urandom;
                end
                if (!req_d && $urandom_range(1, 0) == 1) begin
                    req_d = 1; bus.daddr = $urandom; bus.dstore = $urandom;
                    if ($urandom_range(1, 0) == 1) begin bus.dWEN = 1; bus.dREN = 0; end
                    else                           begin bus.dWEN = 0; bus.dREN = 1; end
                end
                bus.iREN = req_i;
                if (!req_d) begin bus.dREN = 0; bus.dWEN = 0; end
                bus.halt    = ($urandom_range(39, 0) == 0);
                bus.RST     = ($urandom_range(49, 0) == 0);
                bus.ramload = $urandom;
                r = $urandom_range(99, 0);
                bus.ramstate = (r < 40) ? ACCESS : (r < 65) ? BUSY : (r < 85) ? FREE : ERROR;

                @(negedge clk);
                exp_ih = m_serv_i && bus.ramstate == ACCESS && !bus.RST;
                exp_dh = m_serv_d && bus.ramstate == ACCESS && !bus.RST;
                check($sformatf("rnd%0d.%0d ramREN", ep, c), 32'(bus.ramREN),
                      32'(m_serv_i || (m_serv_d && !m_write)));
                check($sformatf("rnd%0d.%0d ramWEN", ep, c), 32'(bus.ramWEN),
                      32'(m_serv_d && m_write));
                check($sformatf("rnd%0d.%0d ramaddr", ep, c), bus.ramaddr, m_addr);
                check($sformatf("rnd%0d.%0d ramstore", ep, c), bus.ramstore, m_store);
                check($sformatf("rnd%0d.%0d ihit", ep, c), 32'(bus.ihit), 32'(exp_ih));
                check($sformatf("rnd%0d.%0d dhit", ep, c), 32'(bus.dhit), 32'(exp_dh));
                check($sformatf("rnd%0d.%0d iload", ep, c), bus.iload, exp_ih ? bus.ramload : 32'h0);
                check($sformatf("rnd%0d.%0d dload", ep, c), bus.dload, exp_dh ? bus.ramload : 32'h0);
                check($sformatf("rnd%0d.%0d halted", ep, c), 32'(bus.halted), 32'(m_parked));
                check($sformatf("rnd%0d.%0d fault", ep, c), 32'(bus.fault), 32'(m_dead));

                @(posedge clk);
                model_step();
                #1;
                if (exp_ih) req_i = 0;
                if (exp_dh) req_d = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
